muldiv_seq: RTL
===============

// Module: muldiv_seq
// PURPOSE
//  Parametrised multi-cycle multiply/divide unit for the execute stage; successor to the divide-only unit.
//  Adds shift-add multiply, WIDTH generalisation, an explicit busy/ready handshake and defined divide-by-zero.
//  The stage hazard logic stalls while busy_o=1 and writes result_o into the HI/LO register on ready_o.
// PARAMETERS
//  WIDTH    32  operand width; result_o is 2*WIDTH bits.
//  CNT_W    $clog2(WIDTH)+1  iteration counter width (derived; do not override).
// PORTS
//  clk       in   1        rising-edge clock.
//  reset     in   1        synchronous, active-high reset.
//  start_i   in   1        start request; accepted when state != CALC.
//  op_i      in   2        00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
//  opa_i     in   WIDTH    multiplicand / dividend, sampled at accepted start.
//  opb_i     in   WIDTH    multiplier / divisor, sampled at accepted start.
//  annul_i   in   1        abort the current operation (exception or flush).
//  busy_o    out  1        1 while in CALC.
//  ready_o   out  1        1-cycle pulse: result_o is valid and newly updated.
//  result_o  out  2*WIDTH  {hi,lo}. MUL: full product. DIV: hi=remainder, lo=quotient.
//  dbz_o     out  1        divide-by-zero flag for the last completed op; held with result_o.
// BEHAVIOUR
//  Reset: state=IDLE; busy_o=0, ready_o=0, result_o=0, dbz_o=0, counter=0.
//  States:
//   - IDLE:
//     - start_i & ~annul_i & ~(div & opb_i==0) -> CALC.
//     - start_i & div & opb_i==0 -> DONE.
//   - CALC: runs WIDTH iterations, one per cycle. counter==WIDTH-1 & ~annul_i -> DONE. annul_i -> IDLE.
//   - DONE (1 cycle): ready_o=1, result_o and dbz_o update this cycle.
//     - start_i -> CALC (or DONE if divide-by-zero); back-to-back ops are allowed.
//     - Otherwise -> IDLE.
//  Start and sign handling:
//   - On start, the unit latches op, the sign flags and |opa|, |opb| as WIDTH-bit unsigned magnitudes.
//   - Unsigned ops take the operands as-is.
//  Multiply:
//   - Radix-2 shift-add over a 2*WIDTH accumulator.
//   - Signed: negate the final product if the operand signs differ.
//  Divide:
//   - Restoring radix-2, one quotient bit per cycle, WIDTH cycles.
//   - Signed: quotient negated if the signs differ; remainder takes the dividend's sign.
//   - MIN_INT / -1 (signed): quotient = MIN_INT (wraps), remainder = 0. No trap.
//  Divide by zero (opb_i==0 with op DIV or DIVU):
//   - Skips CALC; ready_o at T+1.
//   - lo = all ones, hi = opa_i unmodified, dbz_o = 1.
//  Latency:
//   - Start accepted at edge T -> ready_o high in cycle T+WIDTH+1 (33 cycles for WIDTH=32).
//   - busy_o is high from cycle T+1 through T+WIDTH.
//  Hold and handshake rules:
//   - result_o and dbz_o hold their value from ready_o until the next completion.
//   - result_o never changes during CALC; internal accumulators are separate registers.
//   - start_i during CALC is ignored: no restart, no queueing.
//  Annul:
//   - annul_i has priority over start_i in every state.
//   - In CALC: IDLE next cycle, busy_o=0, no ready_o, result_o/dbz_o unchanged.
//   - In DONE: the ready_o pulse still occurs (the result is already committed); a concurrent start_i is dropped.
//  Reset mid-operation: reset has priority over everything; all outputs return to reset values next cycle.
// TESTING
//  1. WIDTH=32, MULT opa=-3 (FFFFFFFD), opb=5 -> ready_o at T+33; result_o = FFFFFFFF_FFFFFFF1; busy_o high 32 cycles.
//  2. MULTU FFFFFFFF * FFFFFFFF -> result_o = FFFFFFFE_00000001. DIVU 100/7 -> hi=2, lo=14, dbz_o=0.
//  3. DIV -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF. DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
//  4. DIVU 1234/0 -> ready_o at T+1, busy_o never high; lo=FFFFFFFF, hi=000004D2, dbz_o=1.
//  5. Annul and reset cases:
//     - annul_i at the 10th CALC cycle -> busy_o=0 next cycle, no ready_o, result_o keeps the prior value; a following MULTU 6*7 -> lo=42.
//     - reset at the 5th CALC cycle -> all outputs return to 0.
//  6. Back-to-back: start_i asserted in the DONE cycle of DIVU 9/3 (result lo=3) with MULT 2*-2 -> second ready_o exactly 33 cycles later, lo=FFFFFFFC.
//     Repeat a random signed/unsigned regression with WIDTH=8 against a reference model.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle shift-add multiply / restoring divide unit with busy/ready handshake
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   opa_i,
  input  logic [WIDTH-1:0]   opb_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               dbz_o
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} stateT;
  stateT state, nextState;
  logic [CNT_W-1:0] cnt;
  logic isDiv, sgnDiff, negA;
  logic [WIDTH-1:0] opd, magA, magB, diff, quot, rem;
  logic [2*WIDTH-1:0] acc, accNext, prod;
  logic [WIDTH:0] sum, shifted;
  logic accept, divZero, lastIter, signedOp, inNegA, inNegB, qBit;
  assign signedOp = ~op_i[0];
  assign inNegA = signedOp & opa_i[WIDTH-1];
  assign inNegB = signedOp & opb_i[WIDTH-1];
  assign magA = inNegA ? -opa_i : opa_i;
  assign magB = inNegB ? -opb_i : opb_i;
  assign accept = start_i & ~annul_i & (state != CALC);
  assign divZero = op_i[1] & (opb_i == '0);
  assign lastIter = cnt == CNT_W'(WIDTH - 1);
  assign busy_o = state == CALC;
  assign ready_o = state == DONE;
  // next state: annul wins, divide-by-zero bypasses the iteration phase
  always_comb begin
    nextState = state;
    if (state == CALC) nextState = annul_i ? IDLE : (lastIter ? DONE : CALC);
    else nextState = accept ? (divZero ? DONE : CALC) : IDLE;
  end
  // state register
  always_ff @(posedge clk) begin
    state <= reset ? IDLE : nextState;
  end
  // one iteration step: mul adds opd into the upper half and shifts right; div shifts left and trial-subtracts
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
    shifted = acc[2*WIDTH-1:WIDTH-1];
    qBit = shifted >= {1'b0, opd};
    diff = shifted[WIDTH-1:0] - opd;
    accNext = isDiv ? {qBit ? diff : shifted[WIDTH-1:0], acc[WIDTH-2:0], qBit} : {sum, acc[WIDTH-1:1]};
    prod = sgnDiff ? -accNext : accNext;
    quot = sgnDiff ? -accNext[WIDTH-1:0] : accNext[WIDTH-1:0];
    rem = negA ? -accNext[2*WIDTH-1:WIDTH] : accNext[2*WIDTH-1:WIDTH];
  end
  // operand latch, accumulator iteration and result commit
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      acc <= '0;
      opd <= '0;
      isDiv <= 1'b0;
      sgnDiff <= 1'b0;
      negA <= 1'b0;
      result_o <= '0;
      dbz_o <= 1'b0;
    end else begin
      cnt <= (state == CALC) ? cnt + 1'b1 : '0;
      if (accept && divZero) begin
        result_o <= {opa_i, {WIDTH{1'b1}}};
        dbz_o <= 1'b1;
      end else if (accept) begin
        isDiv <= op_i[1];
        sgnDiff <= inNegA ^ inNegB;
        negA <= inNegA;
        opd <= op_i[1] ? magB : magA;
        acc <= {{WIDTH{1'b0}}, op_i[1] ? magA : magB};
      end else if (state == CALC && !annul_i) begin
        acc <= accNext;
        if (lastIter) begin
          result_o <= isDiv ? {rem, quot} : prod;
          dbz_o <= 1'b0;
        end
      end
    end
  end
endmodule
